gba_mem_responder: RTL
======================

Name: gba_mem_responder

Overview:
Memory-side responder for the core's external memory interface. It samples A/nMREQ/seq/nRW/mas, inserts programmable N-cycle and S-cycle wait states by driving nWAIT low, and serves reads and writes from an internal word-organised RAM. Addresses outside its page complete with no wait states and assert abort. It sits between the core top and system memory, acting as a GBA-style cartridge or WRAM region model and controller.

Parameters:
ADDR_BITS, 10, word-address width of the internal RAM (2^ADDR_BITS 32-bit words).
BASE_PAGE, 8'h08, value of A[31:24] decoded as a hit.
N_WAIT, 3, wait cycles for a non-sequential access (0..15).
S_WAIT, 1, wait cycles for a sequential access (0..15).

Ports:
mclk  input  1  clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
A  input  32  byte address from the core
nMREQ  input  1  low = memory request this cycle
seq  input  1  high = core claims the access is sequential to the previous one
nRW  input  1  low = read, high = write
mas  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word
DOUT  input  32  write data from the core, lane-replicated by the core
D  output  32  read data to the core (registered)
nWAIT  output  1  low = stretch the current access (registered)
abort  output  1  high during the data cycle of an out-of-page access (registered)

Behaviour:
- Interface: one clock, mclk. Reset is asynchronous and active-high.
- Reset values: D=0, nWAIT=1, abort=0, state=IDLE, last_valid=0. A reset during WAIT or DATA returns the block to IDLE, drops any pending write, and leaves RAM contents unchanged.
- States:
  - IDLE: nWAIT=1. At an edge with nMREQ=0, latch A/nRW/mas and compute W:
    - W = S_WAIT when seq=1, last_valid=1 and A == last_addr + size (size 1/2/4 bytes from mas).
    - Otherwise W = N_WAIT, so an incorrect seq claim costs the N penalty.
    - Out-of-page access (A[31:24] != BASE_PAGE): W forced to 0.
    - Next state is WAIT with cnt=W if W>0, else DATA.
  - WAIT: nWAIT=0. cnt decrements each edge. Leave for DATA at the edge where cnt==1. Bus inputs are ignored; the latched values are used.
  - DATA: nWAIT=1. For a read, D holds the read data. For an out-of-page access, abort=1 and D=0.
    - At the edge ending DATA, a write commits: DOUT is sampled at that edge, only the selected byte lanes are written, and out-of-page writes are discarded.
    - last_addr and last_valid are updated at that edge (last_valid=1 for in-page accesses, 0 for out-of-page).
    - If nMREQ=0 at that same edge, the next request is accepted directly (back-to-back, no IDLE cycle). Otherwise go to IDLE.
- Latency: an access occupies exactly W+1 cycles after the accept edge, W of them with nWAIT=0.
- RAM index = A[ADDR_BITS+1:2]. Higher in-page bits alias (wrap-around).
- Read lane rules: byte reads give {4{byte at A[1:0]}}. Halfword reads give {2{half at A[1]}}, ignoring A[0]. Word reads ignore A[1:0].
- Write lane rules: byte writes enable lane A[1:0] using DOUT[8*A[1:0]+:8]. Halfword writes enable lanes 2*A[1]+{0,1}. Word writes enable all four lanes.
- Outside DATA, D holds its last value and abort=0.
- A read that follows a write to the same word returns the new data, because the commit happens before the next DATA cycle.

Test Plan:
- Reset, then word write of 32'hDEADBEEF to 32'h0800_0010 with seq=0 -> nWAIT low 3 cycles, DATA on the 4th; a following read (N) returns D=32'hDEADBEEF after 3 wait cycles, abort=0.
- Word reads at 0x0800_0010 (N) then 0x0800_0014 (seq=1, back-to-back) -> 3 then 1 wait cycles. A third read with seq=1 to 0x0800_001C -> mismatch, 3 wait cycles.
- Byte write 8'hAA to 0x0800_0013 over word 32'h11223344 -> word read gives 32'hAA223344. Halfword read at 0x0800_0013 gives 32'hAA22AA22. Byte read at 0x0800_0012 gives 32'h22222222.
- Read at 0x0300_0000 -> no wait state, DATA cycle with abort=1 and D=0. A write there leaves RAM unchanged. The next seq=1 access gets the N penalty.
- Assert reset in the 2nd WAIT cycle of a write -> nWAIT=1, D=0 immediately. A later read of that address returns the old data.
- With N_WAIT=0 and S_WAIT=0, back-to-back reads every cycle -> nWAIT stays 1 and new data is returned every cycle.

Source files
------------

// File: rtl/gba_mem_responder.sv
// Memory-side responder for the core's external bus.
// Inserts N/S wait states via nWAIT, serves reads and writes from an internal
// word-organised RAM with byte lanes, and aborts accesses outside its page.
module gba_mem_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter logic [7:0]  BASE_PAGE = 8'h08,
    parameter int unsigned N_WAIT    = 3,
    parameter int unsigned S_WAIT    = 1
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic        nMREQ,
    input  logic        seq,
    input  logic        nRW,
    input  logic [1:0]  mas,
    input  logic [31:0] DOUT,
    output logic [31:0] D,
    output logic        nWAIT,
    output logic        abort
);

    localparam int unsigned DEPTH  = 1 << ADDR_BITS;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_WAIT);
    localparam logic [CNT_W-1:0] S_CNT = CNT_W'(S_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Access size in bytes; the reserved encoding 11 behaves as a word.
    function automatic logic [31:0] size_bytes(input logic [1:0] m);
        case (m)
            2'b00:   size_bytes = 32'd1;
            2'b01:   size_bytes = 32'd2;
            default: size_bytes = 32'd4;
        endcase
    endfunction

    // Byte lanes touched by an access of size m at byte offset a.
    function automatic logic [3:0] lane_en(input logic [1:0] m, input logic [1:0] a);
        case (m)
            2'b00:   lane_en = 4'b0001 << a;
            2'b01:   lane_en = a[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    // Replicate the addressed byte/halfword across the whole data bus.
    function automatic logic [DATA_W-1:0] rd_format(input logic [DATA_W-1:0] w,
                                                    input logic [1:0]        m,
                                                    input logic [1:0]        a);
        case (m)
            2'b00:   rd_format = {4{w[{a, 3'b000} +: 8]}};
            2'b01:   rd_format = {2{w[{a[1], 4'b0000} +: 16]}};
            default: rd_format = w;
        endcase
    endfunction

    // Merge new lane data over an existing word.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [3:0]        be);
        lane_merge = old_w;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                lane_merge[8*k +: 8] = new_w[8*k +: 8];
            end
        end
    endfunction

    logic [DATA_W-1:0] ram [DEPTH];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [1:0]        mas_q, mas_d;
    logic              oob_q, oob_d;
    logic [31:0]       last_addr_q, last_addr_d;
    logic              last_valid_q, last_valid_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              nwait_q, nwait_d;
    logic              abort_q, abort_d;

    logic                 accept_c;
    logic [31:0]          ref_addr_c;
    logic                 ref_valid_c;
    logic                 req_oob_c;
    logic                 req_seq_c;
    logic [CNT_W-1:0]     req_w_c;
    logic                 commit_c;
    logic [ADDR_BITS-1:0] wr_idx_c;
    logic [DATA_W-1:0]    wr_word_c;
    logic [31:0]          rd_addr_c;
    logic [1:0]           rd_mas_c;
    logic [ADDR_BITS-1:0] rd_idx_c;
    logic [DATA_W-1:0]    rd_raw_c;
    logic [DATA_W-1:0]    rd_fmt_c;

    // Request decode: sequential detection against the access just finishing or the last one.
    always_comb begin
        accept_c    = !nMREQ && (state_q == ST_IDLE || state_q == ST_DATA);
        ref_addr_c  = (state_q == ST_DATA) ? addr_q : last_addr_q;
        ref_valid_c = (state_q == ST_DATA) ? !oob_q : last_valid_q;
        req_oob_c   = (A[31:24] != BASE_PAGE);
        req_seq_c   = seq && ref_valid_c && (A == ref_addr_c + size_bytes(mas));
        if (req_oob_c) begin
            req_w_c = '0;
        end else if (req_seq_c) begin
            req_w_c = S_CNT;
        end else begin
            req_w_c = N_CNT;
        end
    end

    // Write commit at the edge ending DATA; DOUT is sampled at that edge.
    always_comb begin
        commit_c  = (state_q == ST_DATA) && wr_q && !oob_q;
        wr_idx_c  = addr_q[ADDR_BITS+1:2];
        wr_word_c = lane_merge(ram[wr_idx_c], DOUT, lane_en(mas_q, addr_q[1:0]));
    end

    // Read path with bypass so a zero-wait read right after a write sees the new word.
    always_comb begin
        rd_addr_c = (state_q == ST_WAIT) ? addr_q : A;
        rd_mas_c  = (state_q == ST_WAIT) ? mas_q : mas;
        rd_idx_c  = rd_addr_c[ADDR_BITS+1:2];
        if (commit_c && (rd_idx_c == wr_idx_c)) begin
            rd_raw_c = wr_word_c;
        end else begin
            rd_raw_c = ram[rd_idx_c];
        end
        rd_fmt_c = rd_format(rd_raw_c, rd_mas_c, rd_addr_c[1:0]);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        mas_d        = mas_q;
        oob_d        = oob_q;
        last_addr_d  = last_addr_q;
        last_valid_d = last_valid_q;
        d_d          = d_q;
        nwait_d      = 1'b1;
        abort_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DATA;
                    abort_d = oob_q;
                    if (oob_q) begin
                        d_d = '0;
                    end else if (!wr_q) begin
                        d_d = rd_fmt_c;
                    end
                end else begin
                    nwait_d = 1'b0;
                end
            end
            ST_DATA: begin
                last_addr_d  = addr_q;
                last_valid_d = !oob_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_c) begin
            addr_d = A;
            wr_d   = nRW;
            mas_d  = mas;
            oob_d  = req_oob_c;
            if (req_w_c != '0) begin
                state_d = ST_WAIT;
                cnt_d   = req_w_c;
                nwait_d = 1'b0;
            end else begin
                state_d = ST_DATA;
                cnt_d   = '0;
                abort_d = req_oob_c;
                if (req_oob_c) begin
                    d_d = '0;
                end else if (!nRW) begin
                    d_d = rd_fmt_c;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            mas_q        <= 2'b00;
            oob_q        <= 1'b0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            d_q          <= '0;
            nwait_q      <= 1'b1;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            mas_q        <= mas_d;
            oob_q        <= oob_d;
            last_addr_q  <= last_addr_d;
            last_valid_q <= last_valid_d;
            d_q          <= d_d;
            nwait_q      <= nwait_d;
            abort_q      <= abort_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge mclk) begin
        if (commit_c) begin
            ram[wr_idx_c] <= wr_word_c;
        end
    end

    assign D     = d_q;
    assign nWAIT = nwait_q;
    assign abort = abort_q;

endmodule
